mem_uart_streamer: RTL
======================

Name: mem_uart_streamer

Overview:
- Read-side initiator for the word-addressed data memory: fetches a contiguous run of words and transmits the low byte of each over a UART line (8N1, LSB first).
- Drives the data memory's read port: 9-bit word address, read enable, 32-bit read data. Memory read is combinational, so data is valid in the same cycle as the read enable.
- Sits beside the CPU as a console/dump engine for text buffers the CPU has written into data memory.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal values ≥ 2.
- ADDR_WIDTH, 9, data memory word-address width.
- LEN_WIDTH, 10, width of the word-count input.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_start  input  1  start request, sampled only in IDLE.
- i_base_addr  input  ADDR_WIDTH  first word address, captured on accept.
- i_length  input  LEN_WIDTH  number of words to send, captured on accept.
- o_mem_address  output  ADDR_WIDTH  word address to data memory.
- o_mem_read  output  1  read enable to data memory.
- i_mem_read_data  input  32  read data from data memory; only bits [7:0] are used.
- o_tx  output  1  UART serial line, idle high.
- o_busy  output  1  high while a transfer is in progress.
- o_done  output  1  one-cycle pulse on transfer completion.

Behaviour:
- Reset values (asynchronous): state=IDLE, o_tx=1, o_busy=0, o_done=0, o_mem_read=0, o_mem_address=0; all counters 0.
- States: IDLE, FETCH, START, DATA, STOP, FIN.
- IDLE:
  - On an edge with i_start=1, capture base address and length.
  - If length=0, go to FIN. Otherwise go to FETCH.
  - i_start is ignored in every other state.
- FETCH (1 cycle):
  - o_mem_read=1, o_mem_address=current address.
  - At the edge, latch i_mem_read_data[7:0] into the shift register, then go to START.
  - o_mem_read is 0 in all other states. o_mem_address holds its last value outside FETCH.
- START: o_tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
- STOP: o_tx=1 for CLKS_PER_BIT cycles. Then:
  - decrement the remaining count and increment the address;
  - if remaining > 0, go to FETCH; otherwise go to FIN.
- Address arithmetic: modulo 2^ADDR_WIDTH, so 511+1 wraps to 0. Word count is not limited by the wrap.
- FIN (1 cycle): o_done=1, then return to IDLE.
- o_busy=1 in FETCH, START, DATA and STOP; 0 in IDLE and FIN.
- Timing:
  - Each word costs 1 + 10*CLKS_PER_BIT cycles.
  - For N ≥ 1 words, o_busy stays high for N*(1 + 10*CLKS_PER_BIT) cycles, starting the cycle after accept.
  - o_done pulses in the following cycle.
- o_tx is registered, with no glitches between bits. Between consecutive words, o_tx stays 1 through the FETCH cycle.
- Reset asserted mid-transfer: immediate abort, o_tx=1, no o_done pulse, and the remaining words are discarded.
- Bits [31:8] of the read data are ignored.

Test Plan:
- Single word: CLKS_PER_BIT=4, RAM[0]=108 (0x6C); start, base=0, len=1 → one FETCH with address 0. o_tx is low for 4 cycles, then bits 0,0,1,1,0,1,1,0 (4 cycles each), then high for 4 cycles. o_busy is high for 41 cycles, then one o_done pulse.
- Multi-word: RAM[0..4]=108,105,110,117,120, base=0, len=5 → bytes 0x6C 0x69 0x6E 0x75 0x78 decoded in order. Addresses 0..4 are each read exactly once. o_busy is high for 205 cycles.
- Wrap and masking: RAM[511]=0x12345641, RAM[0]=0x0A, base=511, len=2 → reads address 511 then 0. Bytes 0x41 then 0x0A are sent.
- Zero length and busy-start: len=0 → o_done pulses in the cycle after accept, o_tx stays 1, o_mem_read never asserts. During a len=1 transfer, pulse i_start with base=7 → ignored: no extra FETCH and no change of address.
- Reset mid-frame: assert reset during DATA bit 3 → o_tx=1, o_busy=0 and o_mem_read=0 immediately (asynchronous), and no o_done. A subsequent start with len=1 transmits a correct full frame.

Source files
------------

// File: rtl/mem_uart_streamer.sv
// mem_uart_streamer: reads a contiguous run of words from the data memory
// and sends the low byte of each word on an 8N1 UART line, LSB first.
//
// Control handshake: i_start is sampled only while idle (o_busy=0 and
// o_done=0). The edge that sees i_start=1 captures i_base_addr and
// i_length. o_busy stays high until the last stop bit has been sent. o_done
// then pulses for exactly one cycle. A zero length skips straight to the
// o_done pulse. Requests made while busy or during the o_done cycle are
// dropped.
module mem_uart_streamer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 9,
  parameter int LEN_WIDTH    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_length,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic                  o_mem_read,
  input  logic [31:0]           i_mem_read_data,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;      // address of the word being sent
  logic [ADDR_WIDTH-1:0] r_mem_addr;  // holds its value outside FETCH
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [7:0]            r_shift;
  logic [2:0]            r_bit;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_tx;

  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_bit_end;
  logic                  w_unused_data;

  assign w_next_addr   = r_addr + ADDR_WIDTH'(1);
  assign w_bit_end     = (r_cnt == CNT_MAX);
  // Only the low byte of each word carries a character.
  assign w_unused_data = ^i_mem_read_data[31:8];

  assign o_mem_address = r_mem_addr;
  assign o_mem_read    = (r_state == S_FETCH);
  assign o_tx          = r_tx;
  assign o_busy        = (r_state == S_FETCH) || (r_state == S_START) ||
                         (r_state == S_DATA)  || (r_state == S_STOP);
  assign o_done        = (r_state == S_FIN);

  // Transfer sequencer: fetch a word, shift out start/data/stop bits,
  // and advance to the next word until the count is exhausted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_remaining <= '0;
      r_shift     <= '0;
      r_bit       <= '0;
      r_cnt       <= '0;
      r_tx        <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr      <= i_base_addr;
            r_remaining <= i_length;
            r_cnt       <= '0;
            if (i_length == '0) begin
              r_state <= S_FIN;
            end else begin
              r_mem_addr <= i_base_addr;
              r_state    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // Memory read is combinational: data is valid this cycle.
          r_shift <= i_mem_read_data[7:0];
          r_tx    <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt       <= '0;
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            r_addr      <= w_next_addr;
            if (r_remaining > LEN_WIDTH'(1)) begin
              r_mem_addr <= w_next_addr;
              r_state    <= S_FETCH;
            end else begin
              r_state <= S_FIN;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
